// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter sequencing accesses to a 1-cycle-latency single-port RAM.
// Define MEM_ARB_FIXED_PRIO_EN to make port 0 win every tie instead of alternating.
`timescale 1ns/1ps

module mem_bus_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
) (
    input  logic              i_Clock,
    input  logic              i_Resetn,

    input  logic              i_P0_Req,
    input  logic              i_P0_Wr,
    input  logic [ADDR_W-1:0] i_P0_Addr,
    input  logic [DATA_W-1:0] i_P0_WrData,
    output logic              o_P0_Ack,
    output logic [DATA_W-1:0] o_P0_RdData,

    input  logic              i_P1_Req,
    input  logic              i_P1_Wr,
    input  logic [ADDR_W-1:0] i_P1_Addr,
    input  logic [DATA_W-1:0] i_P1_WrData,
    output logic              o_P1_Ack,
    output logic [DATA_W-1:0] o_P1_RdData,

    output logic [ADDR_W-1:0] o_Mem_Addr,
    output logic [DATA_W-1:0] o_Mem_WrData,
    output logic              o_Mem_Wren,
    input  logic [DATA_W-1:0] i_Mem_RdData,

    output logic [1:0]        o_Grant,
    output logic              o_Busy,
    output logic [1:0]        o_Dbg_State
);

    // Handshake: a requester holds Req (with Wr/Addr/WrData stable) until it sees a
    // one-cycle Ack; fields are sampled only in the IDLE cycle that grants it, and a
    // Req still high in the IDLE cycle after Ack starts a new transaction.

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RWAIT  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [1:0]          r_grant;
    logic                r_busy;
    logic                r_mem_wren;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wrdata;
    logic                r_p0_ack;
    logic                r_p1_ack;
    logic [DATA_W-1:0]   r_p0_rddata;
    logic [DATA_W-1:0]   r_p1_rddata;
`ifndef MEM_ARB_FIXED_PRIO_EN
    logic                r_last;
`endif

    logic                w_any_req;
    logic                w_pick1;
    logic                w_load;
    logic [1:0]          w_grant_nxt;
    logic                w_busy_nxt;
    logic                w_wren_nxt;
    logic                w_ack0_nxt;
    logic                w_ack1_nxt;
    logic                w_cap0;
    logic                w_cap1;

    // Winner selection; only consulted in IDLE.
    always_comb begin
        w_any_req = i_P0_Req | i_P1_Req;
`ifdef MEM_ARB_FIXED_PRIO_EN
        w_pick1   = i_P1_Req & ~i_P0_Req;
`else
        if (i_P0_Req && i_P1_Req) begin
            w_pick1 = ~r_last;
        end else begin
            w_pick1 = i_P1_Req;
        end
`endif
    end

    always_ff @(posedge i_Clock or negedge i_Resetn) begin
        if (!i_Resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_any_req) w_state_nxt = ST_ACCESS;
            ST_ACCESS: w_state_nxt = r_mem_wren ? ST_DONE : ST_RWAIT;
            ST_RWAIT:  w_state_nxt = ST_DONE;
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; Ack is armed one state early so it
    // appears exactly during DONE.
    always_comb begin
        w_load      = 1'b0;
        w_grant_nxt = r_grant;
        w_busy_nxt  = r_busy;
        w_wren_nxt  = 1'b0;
        w_ack0_nxt  = 1'b0;
        w_ack1_nxt  = 1'b0;
        w_cap0      = 1'b0;
        w_cap1      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_load      = 1'b1;
                    w_grant_nxt = {w_pick1, ~w_pick1};
                    w_busy_nxt  = 1'b1;
                    w_wren_nxt  = w_pick1 ? i_P1_Wr : i_P0_Wr;
                end
            end
            ST_ACCESS: begin
                if (r_mem_wren) begin
                    w_ack0_nxt = r_grant[0];
                    w_ack1_nxt = r_grant[1];
                end
            end
            ST_RWAIT: begin
                w_cap0     = r_grant[0];
                w_cap1     = r_grant[1];
                w_ack0_nxt = r_grant[0];
                w_ack1_nxt = r_grant[1];
            end
            ST_DONE: begin
                w_grant_nxt = 2'b00;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_grant_nxt = 2'b00;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Resetn) begin
        if (!i_Resetn) begin
            r_grant      <= 2'b00;
            r_busy       <= 1'b0;
            r_mem_wren   <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wrdata <= '0;
            r_p0_ack     <= 1'b0;
            r_p1_ack     <= 1'b0;
            r_p0_rddata  <= '0;
            r_p1_rddata  <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            r_last       <= 1'b1;
`endif
        end else begin
            r_grant    <= w_grant_nxt;
            r_busy     <= w_busy_nxt;
            r_mem_wren <= w_wren_nxt;
            r_p0_ack   <= w_ack0_nxt;
            r_p1_ack   <= w_ack1_nxt;
            if (w_load) begin
                r_mem_addr   <= w_pick1 ? i_P1_Addr   : i_P0_Addr;
                r_mem_wrdata <= w_pick1 ? i_P1_WrData : i_P0_WrData;
`ifndef MEM_ARB_FIXED_PRIO_EN
                r_last       <= w_pick1;
`endif
            end
            if (w_cap0) r_p0_rddata <= i_Mem_RdData;
            if (w_cap1) r_p1_rddata <= i_Mem_RdData;
        end
    end

    assign o_P0_Ack     = r_p0_ack;
    assign o_P1_Ack     = r_p1_ack;
    assign o_P0_RdData  = r_p0_rddata;
    assign o_P1_RdData  = r_p1_rddata;
    assign o_Mem_Addr   = r_mem_addr;
    assign o_Mem_WrData = r_mem_wrdata;
    assign o_Mem_Wren   = r_mem_wren;
    assign o_Grant      = r_grant;
    assign o_Busy       = r_busy;
    assign o_Dbg_State  = r_state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: RAM model, port drivers, and a scoreboard monitor
// that checks each transaction's grant, memory strobes, latency and read data.
`timescale 1ns/1ps

module tb_mem_bus_arbiter;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT signals ----------------
  logic        p0_req, p0_wr, p0_ack;
  logic [8:0]  p0_addr;
  logic [15:0] p0_wdata, p0_rdata;
  logic        p1_req, p1_wr, p1_ack;
  logic [8:0]  p1_addr;
  logic [15:0] p1_wdata, p1_rdata;
  logic [8:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        mem_wren;
  logic [1:0]  grant;
  logic        busy;
  logic [1:0]  dbg_state;

  mem_bus_arbiter dut (
    .i_Clock      (clk),
    .i_Resetn     (rst_n),
    .i_P0_Req     (p0_req),
    .i_P0_Wr      (p0_wr),
    .i_P0_Addr    (p0_addr),
    .i_P0_WrData  (p0_wdata),
    .o_P0_Ack     (p0_ack),
    .o_P0_RdData  (p0_rdata),
    .i_P1_Req     (p1_req),
    .i_P1_Wr      (p1_wr),
    .i_P1_Addr    (p1_addr),
    .i_P1_WrData  (p1_wdata),
    .o_P1_Ack     (p1_ack),
    .o_P1_RdData  (p1_rdata),
    .o_Mem_Addr   (mem_addr),
    .o_Mem_WrData (mem_wdata),
    .o_Mem_Wren   (mem_wren),
    .i_Mem_RdData (mem_rdata),
    .o_Grant      (grant),
    .o_Busy       (busy),
    .o_Dbg_State  (dbg_state)
  );

  // Single-port synchronous RAM, data valid the cycle after the address.
  logic [15:0] ram [0:511];
  always @(posedge clk) begin
    if (mem_wren) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [1:0]  grant;
    logic        wr;
    logic [8:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [1:0] g, input logic wr, input logic [8:0] addr,
                          input logic [15:0] wd, input logic [15:0] rd);
    exp_t e;
    e.grant = g;
    e.wr    = wr;
    e.addr  = addr;
    e.wdata = wd;
    e.rdata = rd;
    exp_q.push_back(e);
  endtask

  // Monitor: pops an expectation when a transaction starts, judges it at Ack.
  int          cyc = 0;
  int          rise_cyc = 0;
  int          wren_cnt = 0;
  bit          in_txn = 0;
  bit          after_ack = 0;
  exp_t        cur;
  logic [15:0] m_rd0 = '0;
  logic [15:0] m_rd1 = '0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      in_txn    = 0;
      after_ack = 0;
      m_rd0     = '0;
      m_rd1     = '0;
    end else begin
      if (after_ack) begin
        check("busy_after_done", busy, 0);
        check("grant_after_done", grant, 0);
        after_ack = 0;
      end
      if (!busy) check("wren_idle", mem_wren, 0);
      if (busy && !in_txn) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_txn: grant=%b wren=%b addr=0x%0h, expected no transaction", grant, mem_wren, mem_addr);
          cur       = '0;
          cur.grant = grant;
          cur.wr    = mem_wren;
        end else begin
          cur = exp_q.pop_front();
          check("grant", grant, cur.grant);
          check("access_wren", mem_wren, cur.wr);
          check("access_addr", mem_addr, cur.addr);
          if (cur.wr) check("access_wdata", mem_wdata, cur.wdata);
        end
        in_txn   = 1;
        rise_cyc = cyc;
        wren_cnt = 0;
      end
      if (in_txn && mem_wren) wren_cnt++;
      if (p0_ack || p1_ack) begin
        check("single_ack", p0_ack && p1_ack, 0);
        if (!in_txn) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_ack: p0_ack=%b p1_ack=%b, expected none", p0_ack, p1_ack);
        end else begin
          check("ack_port", {p1_ack, p0_ack}, cur.grant);
          check("ack_busy", busy, 1);
          check("ack_latency", cyc - rise_cyc, cur.wr ? 1 : 2);
          check("wren_cycles", wren_cnt, cur.wr ? 1 : 0);
          if (!cur.wr) begin
            if (cur.grant[1]) m_rd1 = cur.rdata;
            else              m_rd0 = cur.rdata;
          end
          check("p0_rddata", p0_rdata, m_rd0);
          check("p1_rddata", p1_rdata, m_rd1);
          in_txn    = 0;
          after_ack = 1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_port(input int port, input logic req, input logic wr,
                          input logic [8:0] addr, input logic [15:0] wd);
    if (port == 0) begin
      p0_req = req; p0_wr = wr; p0_addr = addr; p0_wdata = wd;
    end else begin
      p1_req = req; p1_wr = wr; p1_addr = addr; p1_wdata = wd;
    end
  endtask

  task automatic wait_ack(input int port);
    int   t;
    logic seen;
    t    = 0;
    seen = 0;
    while (!seen && t < 40) begin
      @(negedge clk);
      t++;
      seen = (port == 0) ? p0_ack : p1_ack;
    end
    check(port == 0 ? "p0_ack_seen" : "p1_ack_seen", seen, 1);
  endtask

  task automatic wait_grant(input logic [1:0] g);
    int t;
    t = 0;
    while (grant !== g && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("grant_seen", grant, g);
  endtask

  // Holds Req for n back-to-back transactions, then drops it after the last Ack.
  task automatic run_port(input int port, input logic wr, input logic [8:0] addr,
                          input logic [15:0] wd, input int n);
    @(posedge clk); #1;
    set_port(port, 1'b1, wr, addr, wd);
    for (int k = 0; k < n; k++) wait_ack(port);
    @(posedge clk); #1;
    set_port(port, 1'b0, 1'b0, 9'h000, 16'h0000);
  endtask

  task automatic check_reset_outputs();
    check("rst_wren", mem_wren, 0);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_p0_ack", p0_ack, 0);
    check("rst_p1_ack", p1_ack, 0);
    check("rst_p0_rddata", p0_rdata, 0);
    check("rst_p1_rddata", p1_rdata, 0);
    check("rst_state", dbg_state, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: run did not reach its summary");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    set_port(0, 1'b0, 1'b0, 9'h000, 16'h0000);
    set_port(1, 1'b0, 1'b0, 9'h000, 16'h0000);
    repeat (2) @(negedge clk);
    check_reset_outputs();
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    #2 rst_n = 1'b1;

    // Write then read back on port 0.
    push_exp(2'b01, 1'b1, 9'h005, 16'hBEEF, 16'h0000);
    run_port(0, 1'b1, 9'h005, 16'hBEEF, 1);
    push_exp(2'b01, 1'b0, 9'h005, 16'h0000, 16'hBEEF);
    run_port(0, 1'b0, 9'h005, 16'h0000, 1);

    // Seed data; the final P1 write leaves port 1 as last served.
    push_exp(2'b01, 1'b1, 9'h020, 16'hAAAA, 16'h0000);
    run_port(0, 1'b1, 9'h020, 16'hAAAA, 1);
    push_exp(2'b01, 1'b1, 9'h030, 16'h0F0F, 16'h0000);
    run_port(0, 1'b1, 9'h030, 16'h0F0F, 1);
    push_exp(2'b10, 1'b1, 9'h021, 16'h5555, 16'h0000);
    run_port(1, 1'b1, 9'h021, 16'h5555, 1);

    // Both ports hold read requests for two transactions each.
`ifdef MEM_ARB_FIXED_PRIO_EN
    push_exp(2'b01, 1'b0, 9'h020, 16'h0000, 16'hAAAA);
    push_exp(2'b01, 1'b0, 9'h020, 16'h0000, 16'hAAAA);
    push_exp(2'b10, 1'b0, 9'h021, 16'h0000, 16'h5555);
    push_exp(2'b10, 1'b0, 9'h021, 16'h0000, 16'h5555);
`else
    push_exp(2'b01, 1'b0, 9'h020, 16'h0000, 16'hAAAA);
    push_exp(2'b10, 1'b0, 9'h021, 16'h0000, 16'h5555);
    push_exp(2'b01, 1'b0, 9'h020, 16'h0000, 16'hAAAA);
    push_exp(2'b10, 1'b0, 9'h021, 16'h0000, 16'h5555);
`endif
    fork
      run_port(0, 1'b0, 9'h020, 16'h0000, 2);
      run_port(1, 1'b0, 9'h021, 16'h0000, 2);
    join

    // P0 read arrives during P1's write ACCESS and must see the new data.
    push_exp(2'b10, 1'b1, 9'h010, 16'h1234, 16'h0000);
    push_exp(2'b01, 1'b0, 9'h010, 16'h0000, 16'h1234);
    fork
      run_port(1, 1'b1, 9'h010, 16'h1234, 1);
      begin
        @(posedge clk); #1;
        wait_grant(2'b10);
        set_port(0, 1'b1, 1'b0, 9'h010, 16'h0000);
        wait_ack(0);
        @(posedge clk); #1;
        set_port(0, 1'b0, 1'b0, 9'h000, 16'h0000);
      end
    join

    // Req dropped during ACCESS: transaction still completes, nothing follows.
    push_exp(2'b01, 1'b0, 9'h005, 16'h0000, 16'hBEEF);
    @(posedge clk); #1;
    set_port(0, 1'b1, 1'b0, 9'h005, 16'h0000);
    wait_grant(2'b01);
    p0_req = 1'b0;
    wait_ack(0);
    repeat (8) @(negedge clk);

    // Reset during the ACCESS of a write aborts it without committing.
    push_exp(2'b10, 1'b1, 9'h030, 16'hDEAD, 16'h0000);
    @(posedge clk); #1;
    set_port(1, 1'b1, 1'b1, 9'h030, 16'hDEAD);
    wait_grant(2'b10);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    set_port(1, 1'b0, 1'b0, 9'h000, 16'h0000);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs();

    push_exp(2'b10, 1'b0, 9'h030, 16'h0000, 16'h0F0F);
    run_port(1, 1'b0, 9'h030, 16'h0000, 1);
    push_exp(2'b01, 1'b0, 9'h005, 16'h0000, 16'hBEEF);
    run_port(0, 1'b0, 9'h005, 16'h0000, 1);

    repeat (6) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-port synchronous RAM (1-cycle read latency) between two requesters.
- Port 0 is the multicycle processor's load/store path; port 1 is the line-drawing engine's pixel/data path.
- Arbitrates round-robin, sequences each access through a fixed-latency FSM, and returns ack plus read data to the winner.
- One transaction in flight at a time.

Parameters:
- ADDR_W, 9: memory address width.
- DATA_W, 16: data word width.

Ports:
- i_Clock  in  1  system clock, rising edge.
- i_Resetn  in  1  asynchronous active-low reset.
- i_P0_Req  in  1  port 0 request; hold high until o_P0_Ack.
- i_P0_Wr  in  1  port 0 write (1) / read (0).
- i_P0_Addr  in  ADDR_W  port 0 address.
- i_P0_WrData  in  DATA_W  port 0 write data.
- o_P0_Ack  out  1  port 0 completion pulse, one cycle.
- o_P0_RdData  out  DATA_W  port 0 read data holding register.
- i_P1_Req, i_P1_Wr, i_P1_Addr, i_P1_WrData, o_P1_Ack, o_P1_RdData: same as port 0, for port 1.
- o_Mem_Addr  out  ADDR_W  RAM address.
- o_Mem_WrData  out  DATA_W  RAM write data.
- o_Mem_Wren  out  1  RAM write enable.
- i_Mem_RdData  in  DATA_W  RAM read data, valid the cycle after the address is presented.
- o_Grant  out  2  one-hot owner of the current transaction; 00 when idle.
- o_Busy  out  1  high in any non-IDLE state.

Behaviour:
- Reset (async, i_Resetn=0):
  - State = IDLE; all outputs 0, including o_Pk_RdData and o_Grant.
  - Last-served pointer = 1, so port 0 wins the first tie.
  - Any in-flight transaction is aborted with no Ack; o_Mem_Wren drops immediately.
- All outputs are registered. No combinational path from inputs to outputs.
- FSM states: IDLE, ACCESS, RWAIT, DONE.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that port.
  - Both requesting: grant the port that is not the last served (round-robin).
  - On grant, at the clock edge:
    - latch Wr/Addr/WrData into o_Mem_* (o_Mem_Wren = Wr);
    - set o_Grant and update the last-served pointer;
    - go to ACCESS.
- ACCESS (1 cycle): RAM sees the address/data; a write commits at the end of this cycle.
  - Write: next state DONE; clear o_Mem_Wren at the edge.
  - Read: next state RWAIT.
- RWAIT (reads only, 1 cycle):
  - Capture i_Mem_RdData into o_Pk_RdData of the granted port at the end of the cycle.
  - Next state DONE.
- DONE (1 cycle):
  - o_Pk_Ack = 1 for the granted port only.
  - Next state IDLE; o_Grant cleared, o_Busy cleared at the edge.
- Latency, from the IDLE grant cycle N:
  - write Ack in N+2;
  - read Ack in N+3, with RdData valid in the same cycle.
  - Minimum request-to-request spacing: 3 cycles for a write, 4 for a read.
- Requester rules:
  - Requester drops Req in the cycle after Ack.
  - If Req is still high in the following IDLE cycle, it is treated as a new transaction.
- Request fields are sampled only at grant. Changes after grant are ignored.
- Req dropped mid-transaction: the transaction still completes and Ack is still issued.
- o_Pk_RdData holds its value until the next read completes on that port. Writes never modify it.
- o_Mem_Addr and o_Mem_WrData hold their last values when idle; o_Mem_Wren is 0 outside ACCESS.
- A request arriving during a non-IDLE state waits. No starvation: under continuous contention the ports alternate strictly.

Optional Feature:
- Macro MEM_ARB_FIXED_PRIO_EN.
- Defined: port 0 always wins a tie in IDLE; the last-served pointer is unused. Port 1 is granted only when port 0 is not requesting.
- Undefined: round-robin as above.
- Latencies are identical in both builds.

Test Plan:
- After reset, P0 write Addr=0x005, Data=0xBEEF → o_Mem_Wren=1 for exactly one cycle (ACCESS), o_P0_Ack in N+2. Then P0 read 0x005 → o_P0_Ack in N+3, o_P0_RdData=0xBEEF.
- P0 and P1 both raise reads in the same cycle, held continuously (re-asserting after each Ack) for 4 transactions → grants P0, P1, P0, P1. With MEM_ARB_FIXED_PRIO_EN: P0, P0, P0, P0.
- P1 writes 0x010=0x1234 while P0 raises a read of 0x010 during P1's ACCESS → P0 waits until P1's DONE and the next IDLE, then reads 0x1234. o_P1_RdData is unchanged.
- P0 read granted, then i_P0_Req dropped in ACCESS → o_P0_Ack still pulses in N+3 with valid data. No spurious second transaction.
- i_Resetn pulsed low during the ACCESS of a write → o_Mem_Wren, o_Grant, o_Busy and Ack go 0 immediately. State is IDLE after release and the next request is served normally.
